// File: rtl/grayscale_row_scheduler_if.sv
// Pixel-side handshakes for the row scheduler: serial RGB in, serial gray out.
// The scheduler is the slave; the pixel source/consumer pair is the master.
interface grayscale_row_scheduler_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] gray_out;

  modport master (
    output in_valid, r_in, g_in, b_in, out_ready,
    input  in_ready, out_valid, gray_out
  );

  modport slave (
    input  in_valid, r_in, g_in, b_in, out_ready,
    output in_ready, out_valid, gray_out
  );
endinterface

// File: rtl/grayscale_row_scheduler.sv
// Frame sequencer for the SIZE-lane row grayscale converter: packs serial RGB into
// lane registers, waits the converter latency, captures the gray row, drains it serially.
//
//   state     | meaning
//   S_IDLE    | waiting for start; both handshakes closed
//   S_LOAD    | accepting one row of RGB pixels into the lane registers
//   S_CONVERT | lanes frozen; counting down the converter pipeline latency
//   S_DRAIN   | emitting captured gray pixels one per out handshake
//   S_DONE    | one-cycle frame-complete pulse
module grayscale_row_scheduler #(
  parameter int SIZE         = 100,
  parameter int ROWS         = 100,
  parameter int CONV_LATENCY = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  grayscale_row_scheduler_if.slave  pix,
  output logic [SIZE-1:0][7:0]      o_r_row_out,
  output logic [SIZE-1:0][7:0]      o_g_row_out,
  output logic [SIZE-1:0][7:0]      o_b_row_out,
  input  logic [SIZE-1:0][7:0]      i_gray_row_in,
  output logic [$clog2(ROWS)-1:0]   o_row_idx,
  output logic [$clog2(SIZE)-1:0]   o_col_idx
);
  localparam int CW = $clog2(SIZE);
  localparam int RW = $clog2(ROWS);
  localparam int LW = (CONV_LATENCY > 0) ? $clog2(CONV_LATENCY + 1) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(CONV_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONVERT, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [LW-1:0]       r_lat;
  logic [SIZE-1:0][7:0] r_red_row;
  logic [SIZE-1:0][7:0] r_grn_row;
  logic [SIZE-1:0][7:0] r_blu_row;
  logic [SIZE-1:0][7:0] r_buf;
  logic [7:0]          r_gray;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;

  logic                w_in_acc;
  logic                w_out_acc;
  logic                w_col_last;
  logic                w_row_last;
  logic [CW-1:0]       w_col_inc;

  assign w_in_acc   = r_in_ready & pix.in_valid;
  assign w_out_acc  = r_out_valid & pix.out_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_col_inc  = r_col + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_next = S_LOAD;
      S_LOAD:    if (w_in_acc && w_col_last) w_state_next = S_CONVERT;
      S_CONVERT: if (r_lat == '0) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_out_acc && w_col_last) w_state_next = w_row_last ? S_DONE : S_LOAD;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they never follow valid/ready combinationally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_lat       <= '0;
      r_red_row   <= '0;
      r_grn_row   <= '0;
      r_blu_row   <= '0;
      r_buf       <= '0;
      r_gray      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == S_LOAD);
      r_out_valid <= (w_state_next == S_DRAIN);
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_row <= '0;
            r_col <= '0;
          end
        end
        S_LOAD: begin
          if (w_in_acc) begin
            r_red_row[r_col] <= pix.r_in;
            r_grn_row[r_col] <= pix.g_in;
            r_blu_row[r_col] <= pix.b_in;
            if (w_col_last) begin
              r_col <= '0;
              r_lat <= LAT_INIT;
            end else begin
              r_col <= w_col_inc;
            end
          end
        end
        S_CONVERT: begin
          if (r_lat == '0) begin
            r_buf  <= i_gray_row_in;
            r_gray <= i_gray_row_in[0];
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        S_DRAIN: begin
          if (w_out_acc) begin
            if (w_col_last) begin
              r_col <= '0;
              if (!w_row_last) r_row <= r_row + RW'(1);
            end else begin
              r_col  <= w_col_inc;
              r_gray <= r_buf[w_col_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix.in_ready  = r_in_ready;
  assign pix.out_valid = r_out_valid;
  assign pix.gray_out  = r_gray;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_r_row_out   = r_red_row;
  assign o_g_row_out   = r_grn_row;
  assign o_b_row_out   = r_blu_row;
  assign o_row_idx     = r_row;
  assign o_col_idx     = r_col;
endmodule

// File: tb/tb_grayscale_row_scheduler.sv
// Scoreboard bench for grayscale_row_scheduler with behavioural pipelined converter models.
module tb_grayscale_row_scheduler;
  localparam int SIZE = 4;
  localparam int ROWS = 2;
  localparam int LAT  = 2;
  localparam int CW   = $clog2(SIZE);
  localparam int RW   = $clog2(ROWS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [SIZE-1:0][7:0] r_row, g_row, b_row, gray_in;
  logic [RW-1:0]        row_idx;
  logic [CW-1:0]        col_idx;

  grayscale_row_scheduler_if pix();

  grayscale_row_scheduler #(.SIZE(SIZE), .ROWS(ROWS), .CONV_LATENCY(LAT)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .pix(pix), .o_r_row_out(r_row), .o_g_row_out(g_row), .o_b_row_out(b_row),
    .i_gray_row_in(gray_in), .o_row_idx(row_idx), .o_col_idx(col_idx)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  function automatic logic [7:0] gray_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int acc;
    acc = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
    return 8'(acc >> 8);
  endfunction

  function automatic logic [SIZE-1:0][7:0] conv_row(input logic [SIZE-1:0][7:0] r,
                                                    input logic [SIZE-1:0][7:0] g,
                                                    input logic [SIZE-1:0][7:0] b);
    logic [SIZE-1:0][7:0] res;
    for (int i = 0; i < SIZE; i++) res[i] = gray_of(r[i], g[i], b[i]);
    return res;
  endfunction

  function automatic logic [7:0] pr_of(input int k); return 8'(k * 37 + 11);  endfunction
  function automatic logic [7:0] pg_of(input int k); return 8'(k * 53 + 5);   endfunction
  function automatic logic [7:0] pb_of(input int k); return 8'(k * 19 + 200); endfunction

  // Two-stage converter model for the main instance.
  logic [SIZE-1:0][7:0] m_s0, m_p1, m_p2;
  always_comb m_s0 = conv_row(r_row, g_row, b_row);
  always @(posedge clk) begin
    m_p1 <= m_s0;
    m_p2 <= m_p1;
  end
  assign gray_in = m_p2;

  // Latency sweep instances; g_sw[3] pairs a latency-1 scheduler with a latency-2 model on purpose.
  logic sw_rst;
  logic sw_start;
  int   sw_gap  [4];
  int   sw_bad  [4];
  int   sw_nout [4];
  int   sw_dcnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int DL = (g == 0) ? 0 : (g == 2) ? 3 : 1;
    localparam int ML = (g == 3) ? 2 : DL;
    grayscale_row_scheduler_if sp();
    logic [SIZE-1:0][7:0] sr, sg, sb, sgray, s0, p1, p2, p3;
    logic [RW-1:0] srow;
    logic [CW-1:0] scol;
    logic sbusy, sdone;
    int kin = 0, kout = 0, ncyc = 0, acc_neg = -1, gap = -1, bad = 0, dcnt = 0;
    bit pend = 1'b0;

    grayscale_row_scheduler #(.SIZE(SIZE), .ROWS(ROWS), .CONV_LATENCY(DL)) u_sw (
      .i_clk(clk), .i_reset(sw_rst), .i_start(sw_start), .o_busy(sbusy), .o_done(sdone),
      .pix(sp), .o_r_row_out(sr), .o_g_row_out(sg), .o_b_row_out(sb),
      .i_gray_row_in(sgray), .o_row_idx(srow), .o_col_idx(scol)
    );

    always_comb s0 = conv_row(sr, sg, sb);
    always @(posedge clk) begin
      p1 <= s0;
      p2 <= p1;
      p3 <= p2;
    end
    assign sgray = (ML == 0) ? s0 : (ML == 1) ? p1 : (ML == 2) ? p2 : p3;

    assign sp.in_valid  = 1'b1;
    assign sp.out_ready = 1'b1;
    assign sp.r_in      = pr_of(kin);
    assign sp.g_in      = pg_of(kin);
    assign sp.b_in      = pb_of(kin);

    always @(negedge clk) begin
      if (sw_rst) begin
        kin = 0; kout = 0; ncyc = 0; acc_neg = -1; gap = -1; bad = 0; dcnt = 0; pend = 1'b0;
      end else begin
        ncyc++;
        if (pend) kin++;
        pend = sp.in_ready;
        if (sp.in_ready && kin == SIZE - 1) acc_neg = ncyc;
        if (sp.out_valid) begin
          if (gap < 0) gap = (ncyc - 1) - acc_neg;
          if (sp.gray_out !== gray_of(pr_of(kout), pg_of(kout), pb_of(kout))) bad++;
          kout++;
        end
        if (sdone) dcnt++;
      end
    end

    assign sw_gap[g]  = gap;
    assign sw_bad[g]  = bad;
    assign sw_nout[g] = kout;
    assign sw_dcnt[g] = dcnt;
  end

  // Frame results reported by run_frame.
  int f_cycles, f_done_cnt, f_nout, f_gap;
  bit f_aborted;

  task automatic run_frame(input int valid_pct, input int stall_at, input bit start_noise, input bit abort_r1);
    int in_cnt, out_cnt, row, stall_left, acc_neg, ncyc, last_lane, exp_col;
    bit bload, finished, stalled_once, trig;
    logic [7:0] pr, pg, pb, lr, lg, lb;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start: busy=%0b done=%0b, expected 0 0", busy, done);
    end
    start = 1'b1;
    pix.in_valid = 1'b0;
    pix.out_ready = 1'b1;
    ncyc = 1; in_cnt = 0; out_cnt = 0; row = 0; stall_left = 0; acc_neg = -1; last_lane = -1;
    bload = 1'b1; finished = 1'b0; stalled_once = 1'b0;
    lr = '0; lg = '0; lb = '0;
    f_gap = -1; f_done_cnt = 0; f_nout = 0; f_aborted = 1'b0; f_cycles = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      ncyc++;
      start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_frame: busy=%0b expected 1 at cycle %0d", busy, ncyc);
      end
      checks++;
      if (done !== finished) begin
        errors++;
        $display("FAIL done_pulse: done=%0b expected %0b at cycle %0d", done, finished, ncyc);
      end
      if (finished) begin
        f_done_cnt += (done === 1'b1) ? 1 : 0;
        f_cycles = ncyc;
        break;
      end
      checks++;
      if (pix.in_ready !== bload) begin
        errors++;
        $display("FAIL in_ready: got %0b expected %0b at cycle %0d", pix.in_ready, bload, ncyc);
      end
      checks++;
      if (bload && pix.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL out_valid_in_load: got %0b expected 0 at cycle %0d", pix.out_valid, ncyc);
      end
      exp_col = bload ? in_cnt : out_cnt;
      checks++;
      if (col_idx !== CW'(exp_col) || row_idx !== RW'(row)) begin
        errors++;
        $display("FAIL indices: row=%0d col=%0d expected row=%0d col=%0d", row_idx, col_idx, row, exp_col);
      end
      if (last_lane >= 0) begin
        checks++;
        if (r_row[last_lane] !== lr || g_row[last_lane] !== lg || b_row[last_lane] !== lb) begin
          errors++;
          $display("FAIL lane_write: lane %0d got %h/%h/%h expected %h/%h/%h", last_lane,
                   r_row[last_lane], g_row[last_lane], b_row[last_lane], lr, lg, lb);
        end
        last_lane = -1;
      end
      if (pix.out_valid === 1'b1) begin
        if (f_gap < 0) f_gap = (ncyc - 1) - acc_neg;
        checks++;
        if (sb_q.size() == 0 || pix.gray_out !== sb_q[0]) begin
          errors++;
          $display("FAIL gray_out: got %h expected %h (queue %0d)", pix.gray_out,
                   (sb_q.size() > 0) ? sb_q[0] : 8'h00, sb_q.size());
        end
      end
      if (abort_r1 && row == 1 && out_cnt == 1 && !bload) begin
        f_aborted = 1'b1;
        break;
      end
      pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
      pix.r_in = pr; pix.g_in = pg; pix.b_in = pb;
      pix.in_valid = ($urandom_range(0, 99) < valid_pct);
      trig = (stall_at >= 0) && !stalled_once && pix.out_valid && (out_cnt == stall_at);
      if (trig) begin
        stall_left = 5;
        stalled_once = 1'b1;
      end
      if (stall_left > 0) begin
        pix.out_ready = 1'b0;
        stall_left--;
      end else begin
        pix.out_ready = 1'b1;
      end
      if (pix.in_ready && pix.in_valid) begin
        sb_q.push_back(gray_of(pr, pg, pb));
        last_lane = in_cnt; lr = pr; lg = pg; lb = pb;
        in_cnt++;
        if (in_cnt == SIZE) begin
          in_cnt = 0;
          bload = 1'b0;
          if (row == 0) acc_neg = ncyc;
        end
      end
      if (pix.out_valid && pix.out_ready) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        f_nout++;
        out_cnt++;
        if (out_cnt == SIZE) begin
          out_cnt = 0;
          if (row == ROWS - 1) finished = 1'b1;
          else begin
            row++;
            bload = 1'b1;
          end
        end
      end
    end
    if (!finished && !f_aborted) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: outputs=%0d expected %0d within cycle budget", f_nout, SIZE * ROWS);
    end
    start = 1'b0;
    pix.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pix.in_ready !== 1'b0 || pix.out_valid !== 1'b0 ||
        pix.gray_out !== 8'h00 || row_idx !== '0 || col_idx !== '0 ||
        r_row !== '0 || g_row !== '0 || b_row !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b ir=%0b ov=%0b gray=%h row=%0d col=%0d, expected all zero",
               busy, done, pix.in_ready, pix.out_valid, pix.gray_out, row_idx, col_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    run_frame(100, -1, 1'b0, 1'b0);
    checks++;
    if (f_nout !== SIZE * ROWS || sb_q.size() != 0) begin
      errors++;
      $display("FAIL basic_count: outputs=%0d left=%0d expected %0d and 0", f_nout, sb_q.size(), SIZE * ROWS);
    end
    checks++;
    if (f_done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d expected 1", f_done_cnt);
    end
    checks++;
    if (f_cycles !== ROWS * (2 * SIZE + LAT + 1) + 2) begin
      errors++;
      $display("FAIL basic_cycles: got %0d expected %0d", f_cycles, ROWS * (2 * SIZE + LAT + 1) + 2);
    end
    checks++;
    if (f_gap !== LAT + 1) begin
      errors++;
      $display("FAIL basic_capture_gap: got %0d expected %0d", f_gap, LAT + 1);
    end
  endtask

  task automatic test_input_gaps();
    run_frame(50, -1, 1'b0, 1'b0);
    checks++;
    if (f_nout !== SIZE * ROWS || sb_q.size() != 0 || f_done_cnt !== 1) begin
      errors++;
      $display("FAIL gaps_frame: outputs=%0d left=%0d done=%0d expected %0d 0 1",
               f_nout, sb_q.size(), f_done_cnt, SIZE * ROWS);
    end
  endtask

  task automatic test_backpressure();
    run_frame(100, 2, 1'b0, 1'b0);
    checks++;
    if (f_nout !== SIZE * ROWS || sb_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: outputs=%0d left=%0d expected %0d 0", f_nout, sb_q.size(), SIZE * ROWS);
    end
    checks++;
    if (f_cycles !== ROWS * (2 * SIZE + LAT + 1) + 2 + 5) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected %0d", f_cycles, ROWS * (2 * SIZE + LAT + 1) + 7);
    end
  endtask

  task automatic test_start_noise();
    run_frame(100, -1, 1'b1, 1'b0);
    checks++;
    if (f_nout !== SIZE * ROWS || f_done_cnt !== 1 || f_cycles !== ROWS * (2 * SIZE + LAT + 1) + 2) begin
      errors++;
      $display("FAIL start_noise: outputs=%0d done=%0d cycles=%0d expected %0d 1 %0d",
               f_nout, f_done_cnt, f_cycles, SIZE * ROWS, ROWS * (2 * SIZE + LAT + 1) + 2);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(100, -1, 1'b0, 1'b0);
    checks++;
    if (f_nout !== SIZE * ROWS || f_done_cnt !== 1 || f_cycles !== ROWS * (2 * SIZE + LAT + 1) + 2) begin
      errors++;
      $display("FAIL back_to_back: outputs=%0d done=%0d cycles=%0d expected %0d 1 %0d",
               f_nout, f_done_cnt, f_cycles, SIZE * ROWS, ROWS * (2 * SIZE + LAT + 1) + 2);
    end
  endtask

  task automatic test_reset_mid_drain();
    run_frame(100, -1, 1'b0, 1'b1);
    checks++;
    if (f_aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_point: reached=%0b expected 1", f_aborted);
    end
    rst = 1'b1;
    pix.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pix.in_ready !== 1'b0 || pix.out_valid !== 1'b0 ||
        pix.gray_out !== 8'h00 || row_idx !== '0 || col_idx !== '0 ||
        r_row !== '0 || g_row !== '0 || b_row !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%0b done=%0b ir=%0b ov=%0b gray=%h row=%0d col=%0d, expected all zero",
               busy, done, pix.in_ready, pix.out_valid, pix.gray_out, row_idx, col_idx);
    end
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_nodone: done=%0b busy=%0b expected 0 0", done, busy);
    end
    run_frame(100, -1, 1'b0, 1'b0);
    checks++;
    if (f_nout !== SIZE * ROWS || f_done_cnt !== 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_frame: outputs=%0d done=%0d left=%0d expected %0d 1 0",
               f_nout, f_done_cnt, sb_q.size(), SIZE * ROWS);
    end
  endtask

  task automatic test_latency_sweep();
    int exp_lat;
    bit all_done;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    @(posedge clk); #1;
    sw_start = 1'b1;
    @(posedge clk); #1;
    sw_start = 1'b0;
    all_done = 1'b0;
    for (int c = 0; c < 200 && !all_done; c++) begin
      @(posedge clk);
      all_done = (sw_dcnt[0] > 0) && (sw_dcnt[1] > 0) && (sw_dcnt[2] > 0) && (sw_dcnt[3] > 0);
    end
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_lat = (g == 0) ? 0 : (g == 2) ? 3 : 1;
      checks++;
      if (sw_gap[g] !== exp_lat + 1) begin
        errors++;
        $display("FAIL sweep_gap[%0d]: got %0d expected %0d", g, sw_gap[g], exp_lat + 1);
      end
      checks++;
      if (sw_nout[g] !== SIZE * ROWS || sw_dcnt[g] !== 1) begin
        errors++;
        $display("FAIL sweep_frame[%0d]: outputs=%0d done=%0d expected %0d 1", g, sw_nout[g], sw_dcnt[g], SIZE * ROWS);
      end
      checks++;
      if (g < 3 && sw_bad[g] !== 0) begin
        errors++;
        $display("FAIL sweep_data[%0d]: bad=%0d expected 0", g, sw_bad[g]);
      end else if (g == 3 && sw_bad[g] == 0) begin
        errors++;
        $display("FAIL sweep_late_model: bad=%0d expected nonzero", sw_bad[g]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sw_rst = 1'b1;
    sw_start = 1'b0;
    pix.in_valid = 1'b0;
    pix.out_ready = 1'b0;
    pix.r_in = '0;
    pix.g_in = '0;
    pix.b_in = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_input_gaps();
    test_backpressure();
    test_start_noise();
    test_back_to_back();
    test_reset_mid_drain();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: done=%0b busy=%0b expected 0 0", done, busy);
    end
    test_latency_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/grayscale_row_scheduler.md
# grayscale_row_scheduler

Sequences a full frame through the SIZE-lane row grayscale converter array. It accepts a serial RGB pixel stream and packs each row into the converter's parallel lane inputs. It waits the converter's fixed pipeline latency, captures the gray row, and streams the gray pixels out serially. The block sits between the pixel source (camera/frame-buffer reader) and the grayscale consumer, and it owns all row/column bookkeeping for the converter.

## Interface
- SIZE, 100, pixels per row; equals converter lane count.
- ROWS, 100, rows per frame.
- CONV_LATENCY, 2, clock edges from a lane-input change to a valid lane output; 0 means the converter is combinational.
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame start request; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last gray pixel of the frame is accepted downstream.
- in_valid / in_ready  input / output  1 / 1  RGB pixel handshake.
- R_in, G_in, B_in  input  8 each  pixel components.
- R_row_out, G_row_out, B_row_out  output  [7:0] x SIZE  registered lane inputs to the converter.
- gray_row_in  input  [7:0] x SIZE  converter lane outputs.
- out_valid / out_ready  output / input  1 / 1  gray pixel handshake.
- gray_out  output  8  current gray pixel.
- row_idx  output  $clog2(ROWS)  current row; col_idx  output  $clog2(SIZE)  current column.

## Operation
- FSM states: IDLE, LOAD, CONVERT, DRAIN, DONE.
- IDLE: in_ready=0, out_valid=0. When start=1, the next state is LOAD, with row_idx=0 and col_idx=0.
- LOAD: in_ready=1.
  - On in_valid&&in_ready, R/G/B are written into lane col_idx of the row registers, and col_idx increments.
  - On the accept at col_idx=SIZE-1, col_idx wraps to 0, the state becomes CONVERT, and the latency counter loads CONV_LATENCY.
  - Lanes not yet written in the current row keep their previous values.
- CONVERT: in_ready=0, out_valid=0, and the row registers are frozen.
  - The counter decrements each cycle. In the cycle where the counter is 0, gray_row_in is captured into a SIZE x 8 output buffer and the state becomes DRAIN.
- DRAIN: out_valid=1 and gray_out=buffer[col_idx].
  - On out_valid&&out_ready, col_idx increments.
  - On the accept at SIZE-1, col_idx wraps to 0. If row_idx=ROWS-1, the state becomes DONE. Otherwise row_idx increments and the state becomes LOAD.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays high in DONE.
- start outside IDLE is ignored. There is no frame queueing.
- The input and output sides never overlap: in_ready and out_valid are never both 1.
- Arithmetic: index counters are sized by $clog2 and wrap explicitly at SIZE-1 and ROWS-1. Comparisons never rely on natural overflow.

## Timing
- Reset (synchronous, priority over everything) sets:
  - state IDLE; busy=0, done=0, in_ready=0, out_valid=0;
  - gray_out=0, row_idx=0, col_idx=0;
  - all R/G/B_row_out lanes 0, output buffer 0, latency counter 0.
- start at edge t: busy=1 and in_ready=1 from cycle t+1.
- Let E0 be the edge of the last accepted input pixel of a row. The capture edge is E0+CONV_LATENCY+1, so CONVERT lasts exactly CONV_LATENCY+1 cycles. out_valid rises in the cycle after the capture edge.
- in_ready, out_valid and gray_out are registered outputs. They depend only on state and indices, never combinationally on in_valid or out_ready.
- gray_out is stable while out_valid=1 and out_ready=0.
- done asserts in the cycle after the final out handshake. IDLE follows one cycle later, and a new start is accepted from that IDLE cycle onward.
- Reset asserted mid-frame (any state) aborts the frame without a done pulse. Partial rows are discarded.
- Minimum frame time with no stalls: ROWS x (2xSIZE + CONV_LATENCY + 1) cycles, plus 1 cycle for start and 1 cycle for DONE.

## Test plan
- Basic frame, SIZE=4, ROWS=2, CONV_LATENCY=2, with a behavioural 2-stage converter model and continuous valid/ready:
  - all 8 gray pixels emerge in order and match the model;
  - done pulses once; busy falls the cycle after done;
  - total cycles equal 2x(8+3)+2.
- Latency sweep CONV_LATENCY=0,1,3:
  - capture occurs exactly CONV_LATENCY+1 cycles after the last row input accept;
  - a model with deliberately wrong timing (outputs ready one cycle late) must fail the compare.
- Input gaps: in_valid random 50%:
  - lane contents are correct;
  - in_ready is never 1 outside LOAD;
  - col_idx advances only on accepts.
- Output backpressure: out_ready held 0 for 5 cycles mid-row:
  - gray_out and col_idx hold;
  - in_ready stays 0;
  - no pixel is dropped or duplicated.
- start pulsed during LOAD, CONVERT and DRAIN: no effect on indices or state. A start in the IDLE cycle after DONE begins the next frame with row_idx=0.
- reset asserted in DRAIN of row 1:
  - next cycle all outputs read their reset values and there is no done pulse;
  - a subsequent start processes a clean full frame.
